// File: rtl/alu_accum_ctrl.sv
// Command-side controller for a 4-bit ALU: owns the accumulator and carry, and sequences IDLE -> EXEC -> RESP.
// A command is accepted at E0, the result is captured at E1, and rsp_valid holds until rsp_ready is seen.
module alu_accum_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_c,
    input  logic [WIDTH-1:0] alu_accout,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_acc,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_CLEAR = 3'b101;

    state_t           state, next_state;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_valid) next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= '0;
            data_r   <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            err      <= 1'b0;
            op_count <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    op_r   <= cmd_op;
                    data_r <= cmd_data;
                end
                EXEC: begin
                    err <= 1'b0;
                    if (!op_r[2]) begin
                        acc   <= alu_accout;
                        carry <= alu_cout;
                    end else if (op_r == OP_LOAD) begin
                        acc   <= data_r;
                        carry <= 1'b0;
                    end else if (op_r == OP_CLEAR) begin
                        acc   <= '0;
                        carry <= 1'b0;
                    end else begin
                        err <= 1'b1;
                    end
                end
                RESP: if (rsp_ready) op_count <= op_count + 1'b1;
                default: ;
            endcase
        end
    end

    // ALU ports show the command operands only while an ALU op is executing.
    always_comb begin
        alu_a = acc;
        alu_b = '0;
        alu_c = 2'b00;
        if (state == EXEC && !op_r[2]) begin
            alu_b = data_r;
            alu_c = op_r[1:0];
        end
    end

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_acc   = acc;
    assign rsp_carry = carry;
    assign rsp_err   = err;

endmodule
